bft_leaf_endpoint: RTL

BFT_LEAF_ENDPOINT -- requirements
Module: bft_leaf_endpoint

---
 rtl/bft_leaf_endpoint.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/bft_leaf_endpoint.sv
// Host-side endpoint for a BFT leaf: injects host packets into the leaf under
// per-port credit flow control, and splits the leaf's output stream into
// credit-update packets and data packets for the host. Data packets pass
// through a 2-entry FIFO; an overflow asks the leaf to resend.
module bft_leaf_endpoint #(
   parameter int PACKET_BITS           = 97,
   parameter int NUM_LEAF_BITS         = 6,
   parameter int NUM_PORT_BITS         = 4,
   parameter int NUM_ADDR_BITS         = 7,
   parameter int PAYLOAD_BITS          = 64,
   parameter int NUM_IN_PORTS          = 7,
   parameter int NUM_BRAM_ADDR_BITS    = 7,
   parameter int FREESPACE_UPDATE_SIZE = 64
) (
   input  logic                   clk_bft,
   input  logic                   reset,
   output logic [PACKET_BITS-1:0] stream_to_leaf,
   input  logic [PACKET_BITS-1:0] stream_from_leaf,
   output logic                   resend,
   input  logic [PACKET_BITS-1:0] host_tx_pkt,
   input  logic                   host_tx_vld,
   output logic                   host_tx_rdy,
   output logic [PACKET_BITS-1:0] host_rx_pkt,
   output logic                   host_rx_vld,
   input  logic                   host_rx_rdy,
   output logic                   drop_err
);

   // The addr field sits below port and above the payload; it is carried
   // through untouched, as are the reserved bits.
   localparam int PORT_LSB = PACKET_BITS - 1 - NUM_LEAF_BITS - NUM_PORT_BITS;
   localparam int ADDR_LSB = PORT_LSB - NUM_ADDR_BITS;
   localparam int CW       = NUM_BRAM_ADDR_BITS + 1;

   localparam logic [CW:0]            CRED_MAX  = (CW+1)'(2**NUM_BRAM_ADDR_BITS);
   localparam logic [CW:0]            CRED_INC  = (CW+1)'(FREESPACE_UPDATE_SIZE);
   localparam logic [CW:0]            CRED_ONE  = (CW+1)'(1);
   localparam logic [NUM_PORT_BITS:0] N_PORTS   = (NUM_PORT_BITS+1)'(NUM_IN_PORTS);
   localparam logic [NUM_PORT_BITS-1:0] PORT_UPD = '1;
   localparam logic [PACKET_BITS-1:0] VLD_MASK  = {1'b1, {(PACKET_BITS-1){1'b0}}};
   // Update index is taken from the payload, which must clear the addr field.
   localparam bit                     UPD_IN_PAYLOAD = (NUM_PORT_BITS <= PAYLOAD_BITS)
                                                       && (ADDR_LSB >= PAYLOAD_BITS);

   logic [CW-1:0]            credit_q [NUM_IN_PORTS];
   logic [CW-1:0]            credit_d [NUM_IN_PORTS];
   logic [PACKET_BITS-1:0]   stl_q, stl_d;
   logic                     drop_q, drop_d;
   logic                     resend_q, resend_d;
   logic [PACKET_BITS-1:0]   fifo_q [2];
   logic [PACKET_BITS-1:0]   fifo_d [2];
   logic [1:0]               cnt_q, cnt_d;

   logic [NUM_PORT_BITS-1:0] tx_port, from_port, upd_idx;
   logic tx_port_ok, tx_credit_nz, tx_xfer, tx_fwd, tx_drop;
   logic from_vld, is_upd, is_data, upd_ok, upd_apply, upd_drop;
   logic pop, push, full;
   logic [1:0] cnt_mid;
   logic [CW:0] sum;

   assign tx_port   = host_tx_pkt[PORT_LSB +: NUM_PORT_BITS];
   assign from_vld  = stream_from_leaf[PACKET_BITS-1];
   assign from_port = stream_from_leaf[PORT_LSB +: NUM_PORT_BITS];
   assign upd_idx   = stream_from_leaf[NUM_PORT_BITS-1:0];

   assign tx_port_ok = {1'b0, tx_port} < N_PORTS;
   assign is_upd     = from_vld && (from_port == PORT_UPD);
   assign is_data    = from_vld && (from_port != PORT_UPD);
   assign upd_ok     = UPD_IN_PAYLOAD && ({1'b0, upd_idx} < N_PORTS);
   assign upd_apply  = is_upd && upd_ok;
   assign upd_drop   = is_upd && !upd_ok;

   // Credit lookup for the port addressed by the packet at the host tx port.
   always_comb begin
      tx_credit_nz = 1'b0;
      for (int p = 0; p < NUM_IN_PORTS; p++) begin
         if (tx_port == NUM_PORT_BITS'(p) && credit_q[p] != '0) tx_credit_nz = 1'b1;
      end
   end

   assign host_tx_rdy = !reset && (!tx_port_ok || tx_credit_nz);
   assign tx_xfer     = host_tx_vld && host_tx_rdy;
   assign tx_fwd      = tx_xfer && tx_port_ok;
   assign tx_drop     = tx_xfer && !tx_port_ok;

   // Credit next-state: add the update before subtracting the inject so a
   // same-cycle pair never dips below zero, then saturate at buffer depth.
   always_comb begin
      sum = '0;
      for (int p = 0; p < NUM_IN_PORTS; p++) begin
         sum = {1'b0, credit_q[p]};
         if (upd_apply && upd_idx == NUM_PORT_BITS'(p)) sum = sum + CRED_INC;
         if (tx_fwd && tx_port == NUM_PORT_BITS'(p))    sum = sum - CRED_ONE;
         credit_d[p] = (sum > CRED_MAX) ? CRED_MAX[CW-1:0] : sum[CW-1:0];
      end
   end

   // Inject path and error pulse next-state.
   always_comb begin
      stl_d  = tx_fwd ? (host_tx_pkt | VLD_MASK) : '0;
      drop_d = tx_drop || upd_drop;
   end

   // Receive FIFO next-state: pop shifts the tail forward; a push lands in
   // the first free slot after the pop. Full with no pop discards and resends.
   always_comb begin
      fifo_d[0] = fifo_q[0];
      fifo_d[1] = fifo_q[1];
      full      = (cnt_q == 2'd2);
      pop       = (cnt_q != 2'd0) && host_rx_rdy;
      push      = is_data && (!full || pop);
      resend_d  = is_data && full && !pop;
      cnt_mid   = cnt_q - {1'b0, pop};
      if (pop) fifo_d[0] = fifo_q[1];
      if (push) begin
         if (cnt_mid == 2'd0) fifo_d[0] = stream_from_leaf;
         else                 fifo_d[1] = stream_from_leaf;
      end
      cnt_d = cnt_mid + {1'b0, push};
   end

   // State registers; reset clears everything and restores full credit.
   always_ff @(posedge clk_bft or posedge reset) begin
      if (reset) begin
         for (int p = 0; p < NUM_IN_PORTS; p++) credit_q[p] <= CRED_MAX[CW-1:0];
         stl_q     <= '0;
         drop_q    <= 1'b0;
         resend_q  <= 1'b0;
         fifo_q[0] <= '0;
         fifo_q[1] <= '0;
         cnt_q     <= 2'd0;
      end else begin
         credit_q  <= credit_d;
         stl_q     <= stl_d;
         drop_q    <= drop_d;
         resend_q  <= resend_d;
         fifo_q    <= fifo_d;
         cnt_q     <= cnt_d;
      end
   end

   assign stream_to_leaf = stl_q;
   assign drop_err       = drop_q;
   assign resend         = resend_q;
   assign host_rx_vld    = (cnt_q != 2'd0);
   assign host_rx_pkt    = fifo_q[0];

endmodule
